branch_resolve_unit: RTL and testbench

- ID-stage consumer of the branch forwarding selects (`fub_cs_1`, `fub_cs_2`).
- Picks each branch operand from the register file, the MEM-stage ALU result or the MEM-stage load data, then compares the operands and computes the branch/JALR target.
- Drives the fetch redirect and the IF/ID flush.
- Owns a one-cycle stall FSM for the case where the producer is still in EX, and keeps resolved/taken performance counters.

---
 rtl/branch_resolve_unit_if.sv | 51 +++++
 rtl/branch_resolve_unit.sv | 121 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolve bundle: decode/forwarding inputs in,
// redirect/stall/counter outputs back to the pipeline.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_is_branch;
    logic             id_is_jalr;
    logic [2:0]       id_funct3;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [XLEN-1:0]  rf_rs1_data;
    logic [XLEN-1:0]  rf_rs2_data;
    logic [1:0]       fub_cs_1;
    logic [1:0]       fub_cs_2;
    logic [XLEN-1:0]  mem_alu_result;
    logic [XLEN-1:0]  mem_read_data;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             pipe_flush;
    logic             stall;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_target;
    logic             flush_if;
    logic             illegal_branch;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output id_valid, id_is_branch, id_is_jalr, id_funct3,
        output id_pc, id_imm, id_rs1, id_rs2,
        output rf_rs1_data, rf_rs2_data, fub_cs_1, fub_cs_2,
        output mem_alu_result, mem_read_data,
        output ex_rd, ex_reg_write, pipe_flush,
        input  stall, redirect_valid, redirect_target, flush_if,
        input  illegal_branch, branch_count, taken_count
    );

    modport slave (
        input  id_valid, id_is_branch, id_is_jalr, id_funct3,
        input  id_pc, id_imm, id_rs1, id_rs2,
        input  rf_rs1_data, rf_rs2_data, fub_cs_1, fub_cs_2,
        input  mem_alu_result, mem_read_data,
        input  ex_rd, ex_reg_write, pipe_flush,
        output stall, redirect_valid, redirect_target, flush_if,
        output illegal_branch, branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/JALR resolver: operand forwarding, compare, target,
// redirect/flush, one-cycle EX-hazard stall and perf counters.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;

    logic            act, hz, resolve, stall;
    logic            br_taken, f3_bad, taken;
    logic [XLEN-1:0] op1, op2, br_tgt, jr_sum, tgt;

    assign act = bus.id_valid & (bus.id_is_branch | bus.id_is_jalr)
               & ~bus.pipe_flush;

    // JALR has no rs2, so only rs1 can create a hazard for it
    assign hz = bus.ex_reg_write & (bus.ex_rd != 5'd0)
              & ((bus.ex_rd == bus.id_rs1)
                 | (bus.id_is_branch & (bus.ex_rd == bus.id_rs2)));

    always_comb begin
        op1 = bus.rf_rs1_data;
        priority case (1'b1)
            (bus.id_rs1 == 5'd0):      op1 = '0;
            (bus.fub_cs_1 == 2'b10):   op1 = bus.mem_alu_result;
            (bus.fub_cs_1 == 2'b01):   op1 = bus.mem_read_data;
            default:                   op1 = bus.rf_rs1_data;
        endcase
    end

    always_comb begin
        op2 = bus.rf_rs2_data;
        priority case (1'b1)
            (bus.id_rs2 == 5'd0):      op2 = '0;
            (bus.fub_cs_2 == 2'b10):   op2 = bus.mem_alu_result;
            (bus.fub_cs_2 == 2'b01):   op2 = bus.mem_read_data;
            default:                   op2 = bus.rf_rs2_data;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        f3_bad   = 1'b0;
        unique case (bus.id_funct3)
            3'b000: br_taken = (op1 == op2);
            3'b001: br_taken = (op1 != op2);
            3'b100: br_taken = ($signed(op1) < $signed(op2));
            3'b101: br_taken = ($signed(op1) >= $signed(op2));
            3'b110: br_taken = (op1 < op2);
            3'b111: br_taken = (op1 >= op2);
            default: f3_bad  = 1'b1;
        endcase
    end

    assign taken  = bus.id_is_branch ? br_taken : 1'b1;
    assign br_tgt = bus.id_pc + bus.id_imm;
    assign jr_sum = op1 + bus.id_imm;
    assign tgt    = bus.id_is_branch ? br_tgt
                                     : {jr_sum[XLEN-1:1], 1'b0};

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (act && hz) begin
                    stall   = 1'b1;
                    state_d = WAIT;
                end else if (act) begin
                    resolve = 1'b1;
                end
            end
            WAIT: begin
                // producer has moved to MEM and is reached via fub_cs
                state_d = IDLE;
                resolve = act;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        if (resolve) begin
            bcnt_d = bcnt_q + CNT_W'(1);
            if (taken) begin
                tcnt_d = tcnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.stall           = stall;
    assign bus.redirect_valid  = resolve & taken;
    assign bus.flush_if        = resolve & taken;
    assign bus.redirect_target = (resolve & taken) ? tgt : '0;
    assign bus.illegal_branch  = resolve & bus.id_is_branch & f3_bad;
    assign bus.branch_count    = bcnt_q;
    assign bus.taken_count     = tcnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: per-cycle expectations are
// queued as stimulus is applied and compared mid-cycle.
module tb_branch_resolve_unit;
    logic clk;
    logic reset;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        ill;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t sb[$];

    int          n_chk;
    int          n_pass;
    logic [31:0] mdl_bc;
    logic [31:0] mdl_tc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // one clock cycle with inputs already applied; ends on next negedge
    task automatic step(input string tag, input logic e_stall,
                        input logic e_rv, input logic [31:0] e_tgt,
                        input logic e_ill, input logic resolved);
        exp_t e;
        exp_t g;
        e.tag   = tag;
        e.stall = e_stall;
        e.rv    = e_rv;
        e.tgt   = e_tgt;
        e.ill   = e_ill;
        e.bc    = mdl_bc;
        e.tc    = mdl_tc;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk({tag, ".sb"}, 64'd0, 64'd1);
        end else begin
            g = sb.pop_front();
            chk({g.tag, ".stall"}, 64'(bus.stall), 64'(g.stall));
            chk({g.tag, ".rv"}, 64'(bus.redirect_valid), 64'(g.rv));
            chk({g.tag, ".flush"}, 64'(bus.flush_if), 64'(g.rv));
            chk({g.tag, ".ill"}, 64'(bus.illegal_branch), 64'(g.ill));
            chk({g.tag, ".bc"}, 64'(bus.branch_count), 64'(g.bc));
            chk({g.tag, ".tc"}, 64'(bus.taken_count), 64'(g.tc));
            if (g.rv) begin
                chk({g.tag, ".tgt"}, 64'(bus.redirect_target),
                    64'(g.tgt));
            end
        end
        if (resolved) begin
            mdl_bc = mdl_bc + 32'd1;
            if (e_rv) mdl_tc = mdl_tc + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.id_valid       = 1'b0;
        bus.id_is_branch   = 1'b0;
        bus.id_is_jalr     = 1'b0;
        bus.id_funct3      = 3'b000;
        bus.id_pc          = '0;
        bus.id_imm         = '0;
        bus.id_rs1         = '0;
        bus.id_rs2         = '0;
        bus.rf_rs1_data    = '0;
        bus.rf_rs2_data    = '0;
        bus.fub_cs_1       = 2'b00;
        bus.fub_cs_2       = 2'b00;
        bus.mem_alu_result = '0;
        bus.mem_read_data  = '0;
        bus.ex_rd          = '0;
        bus.ex_reg_write   = 1'b0;
        bus.pipe_flush     = 1'b0;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [31:0] d1,
                      input logic [31:0] d2);
        idle_in();
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        bus.id_funct3    = f3;
        bus.id_pc        = pc;
        bus.id_imm       = imm;
        bus.id_rs1       = r1;
        bus.id_rs2       = r2;
        bus.rf_rs1_data  = d1;
        bus.rf_rs2_data  = d2;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        mdl_bc = '0;
        mdl_tc = '0;
        idle_in();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step("rst", 0, 0, 32'h0, 0, 0);
        chk("rst.tgt", 64'(bus.redirect_target), 64'h0);

        br(3'b000, 32'h100, 32'h20, 5'd1, 5'd2, 32'd5, 32'd5);
        step("beq", 0, 1, 32'h120, 0, 1);

        br(3'b100, 32'h200, 32'hFFFF_FFF8, 5'd1, 5'd2, 32'd7, 32'd0);
        bus.ex_rd        = 5'd1;
        bus.ex_reg_write = 1'b1;
        step("blt.c0", 1, 0, 32'h0, 0, 0);
        bus.ex_reg_write   = 1'b0;
        bus.ex_rd          = 5'd0;
        bus.fub_cs_1       = 2'b10;
        bus.mem_alu_result = 32'hFFFF_FFFF;
        step("blt.c1", 0, 1, 32'h1F8, 0, 1);

        br(3'b110, 32'h200, 32'hFFFF_FFF8, 5'd1, 5'd2, 32'd7, 32'd0);
        bus.ex_rd        = 5'd1;
        bus.ex_reg_write = 1'b1;
        step("bltu.c0", 1, 0, 32'h0, 0, 0);
        bus.ex_reg_write   = 1'b0;
        bus.ex_rd          = 5'd0;
        bus.fub_cs_1       = 2'b10;
        bus.mem_alu_result = 32'hFFFF_FFFF;
        step("bltu.c1", 0, 0, 32'h0, 0, 1);

        br(3'b001, 32'h300, 32'h40, 5'd0, 5'd3, 32'd0, 32'd9);
        bus.fub_cs_1       = 2'b10;
        bus.mem_alu_result = 32'h55;
        bus.fub_cs_2       = 2'b01;
        bus.mem_read_data  = 32'h0;
        bus.ex_reg_write   = 1'b1;
        step("bne.x0", 0, 0, 32'h0, 0, 1);

        idle_in();
        bus.id_valid     = 1'b1;
        bus.id_is_jalr   = 1'b1;
        bus.id_rs1       = 5'd5;
        bus.id_rs2       = 5'd7;
        bus.rf_rs1_data  = 32'h1003;
        bus.ex_rd        = 5'd7;
        bus.ex_reg_write = 1'b1;
        step("jalr", 0, 1, 32'h1002, 0, 1);

        br(3'b000, 32'hFFFF_FFF0, 32'h20, 5'd0, 5'd0, 32'd1, 32'd2);
        step("wrap", 0, 1, 32'h10, 0, 1);

        br(3'b001, 32'h400, 32'h8, 5'd4, 5'd6, 32'd1, 32'd2);
        bus.ex_rd        = 5'd6;
        bus.ex_reg_write = 1'b1;
        step("pf.c0", 1, 0, 32'h0, 0, 0);
        bus.pipe_flush = 1'b1;
        step("pf.c1", 0, 0, 32'h0, 0, 0);
        bus.pipe_flush = 1'b0;
        bus.rf_rs2_data = 32'd1;
        step("pf.idle", 1, 0, 32'h0, 0, 0);
        bus.ex_reg_write = 1'b0;
        step("pf.res", 0, 0, 32'h0, 0, 1);

        br(3'b010, 32'h500, 32'h8, 5'd1, 5'd2, 32'd3, 32'd3);
        step("ill010", 0, 0, 32'h0, 1, 1);
        br(3'b011, 32'h500, 32'h8, 5'd1, 5'd2, 32'd3, 32'd4);
        step("ill011", 0, 0, 32'h0, 1, 1);

        br(3'b111, 32'h600, 32'h10, 5'd1, 5'd2, 32'd9, 32'd9);
        step("bgeu", 0, 1, 32'h610, 0, 1);

        br(3'b000, 32'h700, 32'h4, 5'd8, 5'd9, 32'd1, 32'd1);
        bus.ex_rd        = 5'd8;
        bus.ex_reg_write = 1'b1;
        step("rw.c0", 1, 0, 32'h0, 0, 0);
        idle_in();
        reset = 1'b1;
        step("rw.rst", 0, 0, 32'h0, 0, 0);
        reset  = 1'b0;
        mdl_bc = '0;
        mdl_tc = '0;
        step("rw.post", 0, 0, 32'h0, 0, 0);
        br(3'b000, 32'h800, 32'h4, 5'd1, 5'd2, 32'd1, 32'd1);
        step("rw.br", 0, 1, 32'h804, 0, 1);
        idle_in();
        step("end", 0, 0, 32'h0, 0, 0);

        chk("sb.empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
